c_frag_ff_array: RTL and testbench

- Parametrised array of NUM_CELLS logic cells; each cell is a C_FRAG-style two-level mux fragment followed by an output flip-flop.
- Generalises the single/split C_FRAG: fragment mode is a parameter, the cell count is configurable, and a registered path is added.
- Adds a per-cell data-select, clock enable and synchronous set, plus an optional cascade chain (QZ of cell i-1 into cell i) that turns the array into a shift register.
- Sits between the routing fabric and the cluster outputs of the PP3 logic tile model.

---
 rtl/c_frag_pkg.sv | 24 ++
 rtl/c_frag_ff_cell.sv | 77 +++++++
 rtl/c_frag_ff_array.sv | 81 ++++++++
 tb/tb_c_frag_ff_array.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/c_frag_pkg.sv
// Shared constants and the two-level fragment mux for the C_FRAG flip-flop array.
// Pure declarations; no state, no flow control.
package c_frag_pkg;

  localparam string C_FRAG_MODE_SINGLE = "SINGLE";
  localparam string C_FRAG_MODE_SPLIT  = "SPLIT";

  localparam int C_FRAG_MIN_CELLS = 1;
  localparam int C_FRAG_MAX_CELLS = 16;

  localparam logic C_FRAG_QZ_RST = 1'b0;

  function automatic logic frag_mux(
    input logic sel,
    input logic ab,
    input logic a1,
    input logic a2,
    input logic b1,
    input logic b2
  );
    return sel ? (ab ? b2 : b1) : (ab ? a2 : a1);
  endfunction

endpackage

// File: rtl/c_frag_ff_cell.sv
// One C_FRAG cell: top/bottom mux fragment, mode-dependent CZ select and output FF.
// TZ/CZ are combinational; QZ updates one edge after sampling; no backpressure.
module c_frag_ff_cell
  import c_frag_pkg::*;
#(
  parameter string MODE = C_FRAG_MODE_SINGLE
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tbs_i,
  input  logic tab_i,
  input  logic tsl_i,
  input  logic ta1_i,
  input  logic ta2_i,
  input  logic tb1_i,
  input  logic tb2_i,
  input  logic bab_i,
  input  logic bsl_i,
  input  logic ba1_i,
  input  logic ba2_i,
  input  logic bb1_i,
  input  logic bb2_i,
  input  logic alt_i,
  input  logic qds_i,
  input  logic qen_i,
  input  logic qst_i,
  output logic tz_o,
  output logic cz_o,
  output logic qz_o
);

  logic tz;
  logic bz;
  logic cz;
  logic qz_d;
  logic qz_q;

  assign tz = frag_mux(tsl_i, tab_i, ta1_i, ta2_i, tb1_i, tb2_i);
  assign bz = frag_mux(bsl_i, bab_i, ba1_i, ba2_i, bb1_i, bb2_i);

  generate
    if (MODE == C_FRAG_MODE_SINGLE) begin : g_single
      assign cz = tbs_i ? bz : tz;
    end else if (MODE == C_FRAG_MODE_SPLIT) begin : g_split
      // Top half runs independently; TBS has no effect on CZ.
      logic unused_tbs;
      assign unused_tbs = tbs_i;
      assign cz         = bz;
    end else begin : g_bad_mode
      $error("c_frag_ff_cell: MODE must be SINGLE or SPLIT");
      assign cz = bz;
    end
  endgenerate

  // Set dominates enable, so a set cell ignores QEN and QDS.
  always_comb begin
    qz_d = qz_q;
    if (qst_i) begin
      qz_d = 1'b1;
    end else if (qen_i) begin
      qz_d = qds_i ? alt_i : cz;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      qz_q <= C_FRAG_QZ_RST;
    end else begin
      qz_q <= qz_d;
    end
  end

  assign tz_o = tz;
  assign cz_o = cz;
  assign qz_o = qz_q;

endmodule

// File: rtl/c_frag_ff_array.sv
// Array of NUM_CELLS C_FRAG cells with registered outputs and optional QZ shift chain.
// TZ/CZ zero latency, QZ one edge; no backpressure.
module c_frag_ff_array
  import c_frag_pkg::*;
#(
  parameter int    NUM_CELLS = 4,
  parameter string MODE      = C_FRAG_MODE_SINGLE,
  parameter int    CHAIN     = 0
) (
  input  logic                 QCK,
  input  logic                 QRT,
  input  logic [NUM_CELLS-1:0] TBS,
  input  logic [NUM_CELLS-1:0] TAB,
  input  logic [NUM_CELLS-1:0] TSL,
  input  logic [NUM_CELLS-1:0] TA1,
  input  logic [NUM_CELLS-1:0] TA2,
  input  logic [NUM_CELLS-1:0] TB1,
  input  logic [NUM_CELLS-1:0] TB2,
  input  logic [NUM_CELLS-1:0] BAB,
  input  logic [NUM_CELLS-1:0] BSL,
  input  logic [NUM_CELLS-1:0] BA1,
  input  logic [NUM_CELLS-1:0] BA2,
  input  logic [NUM_CELLS-1:0] BB1,
  input  logic [NUM_CELLS-1:0] BB2,
  input  logic [NUM_CELLS-1:0] QDI,
  input  logic [NUM_CELLS-1:0] QDS,
  input  logic [NUM_CELLS-1:0] QEN,
  input  logic [NUM_CELLS-1:0] QST,
  output logic [NUM_CELLS-1:0] TZ,
  output logic [NUM_CELLS-1:0] CZ,
  output logic [NUM_CELLS-1:0] QZ
);

  logic [NUM_CELLS-1:0] alt_d;

  generate
    if (NUM_CELLS < C_FRAG_MIN_CELLS || NUM_CELLS > C_FRAG_MAX_CELLS) begin : g_bad_size
      $error("c_frag_ff_array: NUM_CELLS out of range 1..16");
    end

    for (genvar i = 0; i < NUM_CELLS; i++) begin : g_cell
      // Chain taps the registered QZ of the previous cell, so every enabled
      // cell moves exactly one place per edge; a disabled cell just holds.
      if (CHAIN != 0 && i > 0) begin : g_chain
        logic unused_qdi;
        assign unused_qdi = QDI[i];
        assign alt_d[i]   = QZ[i-1];
      end else begin : g_local
        assign alt_d[i] = QDI[i];
      end

      c_frag_ff_cell #(
        .MODE(MODE)
      ) u_cell (
        .clk_i (QCK),
        .rst_ni(QRT),
        .tbs_i (TBS[i]),
        .tab_i (TAB[i]),
        .tsl_i (TSL[i]),
        .ta1_i (TA1[i]),
        .ta2_i (TA2[i]),
        .tb1_i (TB1[i]),
        .tb2_i (TB2[i]),
        .bab_i (BAB[i]),
        .bsl_i (BSL[i]),
        .ba1_i (BA1[i]),
        .ba2_i (BA2[i]),
        .bb1_i (BB1[i]),
        .bb2_i (BB2[i]),
        .alt_i (alt_d[i]),
        .qds_i (QDS[i]),
        .qen_i (QEN[i]),
        .qst_i (QST[i]),
        .tz_o  (TZ[i]),
        .cz_o  (CZ[i]),
        .qz_o  (QZ[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_c_frag_ff_array.sv
// Bench for c_frag_ff_array: a SINGLE/CHAIN=1 array and a SPLIT/CHAIN=0 array share stimulus;
// a reference model pushes expected outputs that a monitor pops after every edge.
module tb_c_frag_ff_array;

  localparam int N = 4;

  logic         clk;
  logic         qrt;
  logic [N-1:0] tbs, tab, tsl, ta1, ta2, tb1, tb2;
  logic [N-1:0] bab, bsl, ba1, ba2, bb1, bb2;
  logic [N-1:0] qdi, qds, qen, qst;
  logic [N-1:0] tz_s, cz_s, qz_s;
  logic [N-1:0] tz_p, cz_p, qz_p;

  typedef struct {
    logic [N-1:0] tz;
    logic [N-1:0] cz_s;
    logic [N-1:0] cz_p;
    logic [N-1:0] qz_s;
    logic [N-1:0] qz_p;
  } exp_t;

  exp_t         exp_q[$];
  logic [N-1:0] ms_q;
  logic [N-1:0] mp_q;
  int           total;
  int           bad;

  c_frag_ff_array #(.NUM_CELLS(N), .MODE("SINGLE"), .CHAIN(1)) u_single (
    .QCK(clk), .QRT(qrt), .TBS(tbs), .TAB(tab), .TSL(tsl), .TA1(ta1), .TA2(ta2),
    .TB1(tb1), .TB2(tb2), .BAB(bab), .BSL(bsl), .BA1(ba1), .BA2(ba2), .BB1(bb1),
    .BB2(bb2), .QDI(qdi), .QDS(qds), .QEN(qen), .QST(qst),
    .TZ(tz_s), .CZ(cz_s), .QZ(qz_s)
  );

  c_frag_ff_array #(.NUM_CELLS(N), .MODE("SPLIT"), .CHAIN(0)) u_split (
    .QCK(clk), .QRT(qrt), .TBS(tbs), .TAB(tab), .TSL(tsl), .TA1(ta1), .TA2(ta2),
    .TB1(tb1), .TB2(tb2), .BAB(bab), .BSL(bsl), .BA1(ba1), .BA2(ba2), .BB1(bb1),
    .BB2(bb2), .QDI(qdi), .QDS(qds), .QEN(qen), .QST(qst),
    .TZ(tz_p), .CZ(cz_p), .QZ(qz_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%b required=%b at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic clear_inputs();
    {tbs, tab, tsl, ta1, ta2, tb1, tb2} = '0;
    {bab, bsl, ba1, ba2, bb1, bb2}      = '0;
    {qdi, qds, qen, qst}                = '0;
  endtask

  task automatic random_inputs();
    tbs = N'($urandom); tab = N'($urandom); tsl = N'($urandom); ta1 = N'($urandom);
    ta2 = N'($urandom); tb1 = N'($urandom); tb2 = N'($urandom); bab = N'($urandom);
    bsl = N'($urandom); ba1 = N'($urandom); ba2 = N'($urandom); bb1 = N'($urandom);
    bb2 = N'($urandom); qdi = N'($urandom); qds = N'($urandom); qen = N'($urandom);
    qst = N'($urandom);
  endtask

  // Reference model: evaluates the current inputs and advances the model
  // state to what both arrays must hold after the coming rising edge.
  task automatic push_exp();
    exp_t         e;
    logic [N-1:0] ns, np;
    for (int i = 0; i < N; i++) begin
      logic t, b, cs, cp, as, ap, ds, dp;
      t  = tsl[i] ? (tab[i] ? tb2[i] : tb1[i]) : (tab[i] ? ta2[i] : ta1[i]);
      b  = bsl[i] ? (bab[i] ? bb2[i] : bb1[i]) : (bab[i] ? ba2[i] : ba1[i]);
      cs = tbs[i] ? b : t;
      cp = b;
      as = (i == 0) ? qdi[0] : ms_q[i-1];
      ap = qdi[i];
      ds = qds[i] ? as : cs;
      dp = qds[i] ? ap : cp;
      e.tz[i]   = t;
      e.cz_s[i] = cs;
      e.cz_p[i] = cp;
      ns[i] = !qrt ? 1'b0 : qst[i] ? 1'b1 : qen[i] ? ds : ms_q[i];
      np[i] = !qrt ? 1'b0 : qst[i] ? 1'b1 : qen[i] ? dp : mp_q[i];
    end
    ms_q   = ns;
    mp_q   = np;
    e.qz_s = ns;
    e.qz_p = np;
    exp_q.push_back(e);
  endtask

  // Monitor: one expectation per edge, compared 1 time unit after it.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("tz_single", tz_s, e.tz);
        check("tz_split",  tz_p, e.tz);
        check("cz_single", cz_s, e.cz_s);
        check("cz_split",  cz_p, e.cz_p);
        check("qz_single", qz_s, e.qz_s);
        check("qz_split",  qz_p, e.qz_p);
      end
    end
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    logic [3:0] chain_bits;
    logic [3:0] fill_bits;
    logic [5:0] vv;
    total = 0;
    bad   = 0;
    ms_q  = '0;
    mp_q  = '0;
    qrt   = 1'b0;
    clear_inputs();

    // Reset held with set and enable on every cell.
    repeat (3) begin
      @(negedge clk);
      random_inputs();
      qrt = 1'b0; qst = '1; qen = '1;
      push_exp();
    end
    @(posedge clk); #2;
    check("reset_hold_single", qz_s, 4'b0000);
    check("reset_hold_split",  qz_p, 4'b0000);

    @(negedge clk);
    random_inputs();
    qrt = 1'b1; qst = 4'b0001; qen = 4'b0000;
    push_exp();
    @(posedge clk); #2;
    check("release_set_single", qz_s, 4'b0001);
    check("release_set_split",  qz_p, 4'b0001);

    // Directed fragment mux on cell 0.
    @(negedge clk);
    clear_inputs(); ta1[0] = 1'b1;
    push_exp();
    #2;
    check("frag_ta1_tz_cz", {2'b00, cz_s[0], tz_s[0]}, 4'b0011);
    @(negedge clk);
    clear_inputs(); ta1[0] = 1'b1; tbs[0] = 1'b1; bsl[0] = 1'b1; bab[0] = 1'b1; bb2[0] = 1'b0;
    push_exp();
    #2;
    check("frag_tbs_tz_cz", {2'b00, cz_s[0], tz_s[0]}, 4'b0001);

    for (int v = 0; v < 64; v++) begin
      @(negedge clk);
      random_inputs();
      vv = v[5:0];
      {tsl[0], tab[0], ta1[0], ta2[0], tb1[0], tb2[0]} = vv;
      {bsl[0], bab[0], ba1[0], ba2[0], bb1[0], bb2[0]} = ~vv;
      push_exp();
    end

    // SPLIT: CZ follows the bottom half whatever TBS says.
    for (int s = 1; s >= 0; s--) begin
      @(negedge clk);
      clear_inputs(); tbs[0] = s[0]; ba1[0] = 1'b1;
      push_exp();
      #2;
      check("split_cz_ignores_tbs", {3'b000, cz_p[0]}, 4'b0001);
    end

    // Shift chain: feed 1,0,1,1 into cell 0.
    chain_bits = 4'b1011;
    for (int k = 3; k >= 0; k--) begin
      @(negedge clk);
      clear_inputs(); qds = '1; qen = '1; qdi[0] = chain_bits[k];
      push_exp();
    end
    @(posedge clk); #2;
    check("chain_shift", qz_s, 4'b1011);

    // Refill to 0110, then one edge with cell 1 disabled.
    fill_bits = 4'b0110;
    for (int k = 3; k >= 0; k--) begin
      @(negedge clk);
      clear_inputs(); qds = '1; qen = '1; qdi[0] = fill_bits[k];
      push_exp();
    end
    @(negedge clk);
    clear_inputs(); qds = '1; qen = 4'b1101; qdi[0] = 1'b0;
    push_exp();
    @(posedge clk); #2;
    check("chain_enable_gap", qz_s, 4'b1110);

    // Set beats disabled enable and alternate data; then async clear mid-cycle.
    @(negedge clk);
    clear_inputs(); qst = '1; qen = '0; qds = '1; qdi = '0;
    push_exp();
    @(posedge clk); #2;
    check("set_priority_single", qz_s, 4'b1111);
    check("set_priority_split",  qz_p, 4'b1111);
    #1 qrt = 1'b0;
    #1;
    check("async_clear_single", qz_s, 4'b0000);
    check("async_clear_split",  qz_p, 4'b0000);
    ms_q = '0;
    mp_q = '0;

    repeat (300) begin
      @(negedge clk);
      random_inputs();
      qrt = ($urandom_range(0, 19) != 0);
      push_exp();
    end

    @(posedge clk); #2;
    check("scoreboard_drained", N'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
